fence_flush_scheduler: RTL

//  Serialises fence-class flush requests from NrThreads hardware threads onto the single

---
 rtl/ariane_pkg.sv | 32 +++
 rtl/fence_rr_arbiter.sv | 31 +++
 rtl/fence_flush_scheduler.sv | 132 +++++++++++++
 3 files changed

// File: rtl/ariane_pkg.sv
// Shared core types: flush request kinds and the
// per-kind step decode used by the flush scheduler.
package ariane_pkg;

  typedef enum logic [1:0] {
    FLUSH_FENCE   = 2'b00,
    FLUSH_FENCE_I = 2'b01,
    FLUSH_SFENCE  = 2'b10,
    FLUSH_FULL    = 2'b11
  } flush_kind_e;

  function automatic logic needs_dcache(
    flush_kind_e k
  );
    return k != FLUSH_SFENCE;
  endfunction

  function automatic logic needs_icache(
    flush_kind_e k
  );
    return (k == FLUSH_FENCE_I) ||
           (k == FLUSH_FULL);
  endfunction

  function automatic logic needs_tlb(
    flush_kind_e k
  );
    return (k == FLUSH_SFENCE) ||
           (k == FLUSH_FULL);
  endfunction

endpackage

// File: rtl/fence_rr_arbiter.sv
// Combinational round-robin pick: first requester
// at or after ptr_i, wrapping; pointer lives in parent.
module fence_rr_arbiter #(
  parameter int unsigned NrThreads = 2,
  localparam int unsigned ThreadIdW =
    (NrThreads > 1) ? $clog2(NrThreads) : 1
) (
  input  logic [NrThreads-1:0] req_i,
  input  logic [ThreadIdW-1:0] ptr_i,
  output logic [NrThreads-1:0] gnt_o,
  output logic [ThreadIdW-1:0] idx_o,
  output logic                 valid_o
);

  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    for (int unsigned i = 0; i < NrThreads; i++) begin
      int unsigned j;
      j = 32'(ptr_i) + i;
      if (j >= NrThreads) j = j - NrThreads;
      if (!valid_o && req_i[j]) begin
        valid_o  = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = ThreadIdW'(j);
      end
    end
  end

endmodule

// File: rtl/fence_flush_scheduler.sv
// Serialises per-thread fence flushes onto the shared
// dcache -> icache -> TLB flush sequence.
module fence_flush_scheduler
  import ariane_pkg::*;
#(
  parameter int unsigned NrThreads     = 2,
  parameter int unsigned TimeoutCycles = 256,
  localparam int unsigned ThreadIdW =
    (NrThreads > 1) ? $clog2(NrThreads) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NrThreads-1:0]   req_valid_i,
  input  logic [2*NrThreads-1:0] req_kind_i,
  output logic [NrThreads-1:0]   req_ready_o,
  output logic [NrThreads-1:0]   done_o,
  output logic                   flush_dcache_o,
  input  logic                   flush_dcache_ack_i,
  output logic                   flush_icache_o,
  output logic                   flush_tlb_o,
  output logic [ThreadIdW-1:0]   flush_thread_id_o,
  output logic                   busy_o,
  output logic                   timeout_o
);

  localparam int unsigned TimerW = $clog2(TimeoutCycles);
  localparam logic [ThreadIdW-1:0] LastId =
    ThreadIdW'(NrThreads - 1);
  localparam logic [TimerW-1:0] TimerMax =
    TimerW'(TimeoutCycles - 1);

  typedef enum logic [2:0] {
    IDLE,
    DC_REQ,
    IC_FLUSH,
    TLB_FLUSH,
    DONE
  } state_e;

  state_e               state_q, state_d;
  flush_kind_e          kind_q, gnt_kind;
  logic [ThreadIdW-1:0] rr_ptr_q, tid_q, gnt_idx;
  logic [NrThreads-1:0] gnt;
  logic                 gnt_valid, take;
  logic [TimerW-1:0]    timer_q;
  logic                 timeout_hit;

  fence_rr_arbiter #(
    .NrThreads(NrThreads)
  ) u_arb (
    .req_i  (req_valid_i),
    .ptr_i  (rr_ptr_q),
    .gnt_o  (gnt),
    .idx_o  (gnt_idx),
    .valid_o(gnt_valid)
  );

  // Grant is combinational but never while reset is applied.
  assign take = rst_ni && (state_q == IDLE) && gnt_valid;
  assign req_ready_o = take ? gnt : '0;
  assign gnt_kind =
    flush_kind_e'(req_kind_i[{gnt_idx, 1'b0} +: 2]);
  assign flush_thread_id_o = tid_q;

  always_comb begin
    state_d     = state_q;
    timeout_hit = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (take) begin
          if (needs_dcache(gnt_kind))      state_d = DC_REQ;
          else if (needs_icache(gnt_kind)) state_d = IC_FLUSH;
          else                             state_d = TLB_FLUSH;
        end
      end
      DC_REQ: begin
        if (flush_dcache_ack_i) begin
          if (needs_icache(kind_q))     state_d = IC_FLUSH;
          else if (needs_tlb(kind_q))   state_d = TLB_FLUSH;
          else                          state_d = DONE;
        end else if (timer_q == TimerMax) begin
          state_d     = DONE;
          timeout_hit = 1'b1;
        end
      end
      IC_FLUSH:
        state_d = needs_tlb(kind_q) ? TLB_FLUSH : DONE;
      TLB_FLUSH: state_d = DONE;
      DONE:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q        <= IDLE;
      kind_q         <= FLUSH_FENCE;
      rr_ptr_q       <= '0;
      tid_q          <= '0;
      timer_q        <= '0;
      timeout_o      <= 1'b0;
      busy_o         <= 1'b0;
      flush_dcache_o <= 1'b0;
      flush_icache_o <= 1'b0;
      flush_tlb_o    <= 1'b0;
      done_o         <= '0;
    end else begin
      state_q        <= state_d;
      busy_o         <= state_d != IDLE;
      flush_dcache_o <= state_d == DC_REQ;
      flush_icache_o <= state_d == IC_FLUSH;
      flush_tlb_o    <= state_d == TLB_FLUSH;
      done_o         <= (state_d == DONE) ?
                        (NrThreads'(1) << tid_q) : '0;
      timeout_o      <= timeout_o | timeout_hit;
      if (take) begin
        tid_q    <= gnt_idx;
        kind_q   <= gnt_kind;
        rr_ptr_q <= (gnt_idx == LastId) ?
                    '0 : gnt_idx + 1'b1;
      end else if (state_d == IDLE) begin
        tid_q <= '0;
      end
      // Only counts while still waiting, so it saturates at TimerMax.
      if (state_q == DC_REQ && state_d == DC_REQ)
        timer_q <= timer_q + 1'b1;
      else if (state_q == DONE)
        timer_q <= '0;
    end
  end

endmodule
